// File: rtl/mux_tree_tapbuf_cfgchain.sv
// mux_tree_tapbuf_cfgchain: routing mux whose select code is shifted in over a config chain and committed atomically.
module mux_tree_tapbuf_cfgchain #(
    parameter int NUM_IN  = 38,
    parameter bit OUT_REG = 1'b0
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              cfg_en,
    input  logic              cfg_load,
    input  logic              ccff_head,
    output logic              ccff_tail,
    input  logic [NUM_IN-1:0] in,
    output logic              out,
    output logic              sel_valid,
    output logic              cfg_err
);
    localparam int SEL_W = $clog2(NUM_IN);
    localparam int CNT_W = $clog2(SEL_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SEL_W);

    logic [SEL_W-1:0] sreg, sel;
    logic [CNT_W-1:0] cnt;
    logic             mux;

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            sreg    <= '0;
            sel     <= '0;
            cnt     <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (cfg_en)
                sreg <= (sreg << 1) | SEL_W'(ccff_head);
            if (cfg_load)
                sel <= sreg;
            if (cfg_load)
                cnt <= cfg_en ? CNT_W'(1) : '0;
            else if (cfg_en && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            if (cfg_load && cnt < CNT_MAX)
                cfg_err <= 1'b1;
        end
    end

    assign ccff_tail = sreg[SEL_W-1];
    assign sel_valid = int'(sel) < NUM_IN;

    // codes beyond NUM_IN route a constant 1
    always_comb begin
        mux = 1'b1;
        for (int k = 0; k < NUM_IN; k++)
            if (sel == SEL_W'(k))
                mux = in[k];
    end

    if (OUT_REG) begin : g_reg
        logic out_q;
        always_ff @(posedge prog_clk)
            out_q <= !prog_reset_n ? 1'b0 : mux;
        assign out = out_q;
    end else begin : g_comb
        assign out = mux;
    end
endmodule

// File: tb/tb_mux_tree_tapbuf_cfgchain.sv
// tb_mux_tree_tapbuf_cfgchain: scoreboard bench driving a combinational and a registered instance in parallel.
module tb_mux_tree_tapbuf_cfgchain;
    localparam int N = 38;

    logic         prog_clk = 1'b0;
    logic         prog_reset_n = 1'b0;
    logic         cfg_en = 1'b0;
    logic         cfg_load = 1'b0;
    logic         ccff_head = 1'b0;
    logic [N-1:0] in = '0;
    logic         ccff_tail, out, sel_valid, cfg_err;
    logic         ccff_tail_r, out_r, sel_valid_r, cfg_err_r;

    int checks = 0;
    int fails = 0;
    logic exp_q[$];

    always #5 prog_clk = ~prog_clk;

    mux_tree_tapbuf_cfgchain #(.NUM_IN(N), .OUT_REG(1'b0)) dut (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .cfg_en(cfg_en), .cfg_load(cfg_load),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail), .in(in), .out(out),
        .sel_valid(sel_valid), .cfg_err(cfg_err)
    );

    mux_tree_tapbuf_cfgchain #(.NUM_IN(N), .OUT_REG(1'b1)) dut_r (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .cfg_en(cfg_en), .cfg_load(cfg_load),
        .ccff_head(ccff_head), .ccff_tail(ccff_tail_r), .in(in), .out(out_r),
        .sel_valid(sel_valid_r), .cfg_err(cfg_err_r)
    );

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic rand_in();
        in = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        prog_reset_n = 1'b0;
        cfg_en = 1'b1;
        cfg_load = 1'b1;
        rand_in();
        tick();
        tick();
        prog_reset_n = 1'b1;
        cfg_en = 1'b0;
        cfg_load = 1'b0;
        #1;
    endtask

    task automatic shift_bits(input logic [5:0] code, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ccff_head = code[i];
            cfg_en = 1'b1;
            tick();
        end
        cfg_en = 1'b0;
    endtask

    task automatic do_load();
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic test_route(input string name, input int k);
        logic e;
        for (int j = 0; j < 2; j++) begin
            in = (j == 0) ? (N'(1) << k) : ~(N'(1) << k);
            exp_q.push_back(j == 0);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin
                $display("FAIL %s: out=%b expected %b (in[%0d] routed)", name, out, e, k);
                fails++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ccff_tail !== 1'b0) begin $display("FAIL reset_tail: got %b expected 0", ccff_tail); fails++; end
        checks++;
        if (cfg_err !== 1'b0) begin $display("FAIL reset_err: got %b expected 0", cfg_err); fails++; end
        checks++;
        if (sel_valid !== 1'b1) begin $display("FAIL reset_valid: got %b expected 1", sel_valid); fails++; end
        checks++;
        if (out_r !== 1'b0) begin $display("FAIL reset_out_reg: got %b expected 0", out_r); fails++; end
        test_route("reset_out_in0", 0);
    endtask

    task automatic test_full_load();
        logic held, e;
        rand_in();
        in[0] = 1'b0;
        in[37] = 1'b1;
        #1;
        held = out;
        for (int i = 5; i >= 0; i--) begin
            ccff_head = (6'd37 >> i) & 1'b1;
            cfg_en = 1'b1;
            tick();
            checks++;
            if (out !== 1'b0 || held !== 1'b0) begin
                $display("FAIL shift_glitch: out=%b expected 0 during shift", out);
                fails++;
            end
        end
        cfg_en = 1'b0;
        do_load();
        for (int t = 0; t < 4; t++) begin
            in[37] = ~in[37];
            exp_q.push_back(in[37]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin $display("FAIL full_load_track: out=%b expected %b", out, e); fails++; end
        end
        checks++;
        if (cfg_err !== 1'b0) begin $display("FAIL full_load_err: got %b expected 0", cfg_err); fails++; end
    endtask

    task automatic test_out_of_range();
        shift_bits(6'd40, 6);
        do_load();
        for (int t = 0; t < 3; t++) begin
            rand_in();
            #1;
            checks++;
            if (sel_valid !== 1'b0 || out !== 1'b1) begin
                $display("FAIL oor_const: sel_valid=%b out=%b expected 0/1", sel_valid, out);
                fails++;
            end
        end
        shift_bits(6'd5, 6);
        do_load();
        checks++;
        if (sel_valid !== 1'b1) begin $display("FAIL oor_back_valid: got %b expected 1", sel_valid); fails++; end
        test_route("oor_back_route", 5);
    endtask

    task automatic test_chain();
        logic [11:0] bits = 12'b110010_011101;
        logic e;
        for (int k = 1; k <= 12; k++) begin
            ccff_head = bits[12 - k];
            cfg_en = 1'b1;
            if (k >= 6) exp_q.push_back(bits[12 - (k - 5)]);
            tick();
            if (k >= 6) begin
                e = exp_q.pop_front();
                checks++;
                if (ccff_tail !== e) begin
                    $display("FAIL chain_tail_edge%0d: got %b expected %b", k, ccff_tail, e);
                    fails++;
                end
            end
        end
        cfg_en = 1'b0;
        do_load();
        checks++;
        if (cfg_err !== 1'b0) begin $display("FAIL chain_err: got %b expected 0", cfg_err); fails++; end
        test_route("chain_sel29", 29);
    endtask

    task automatic test_under_shift();
        do_reset();
        shift_bits(6'b000101, 3);
        do_load();
        checks++;
        if (cfg_err !== 1'b1) begin $display("FAIL under_err: got %b expected 1", cfg_err); fails++; end
        test_route("under_partial_sel5", 5);
        shift_bits(6'd12, 6);
        do_load();
        checks++;
        if (cfg_err !== 1'b1) begin $display("FAIL under_sticky: got %b expected 1", cfg_err); fails++; end
        test_route("under_full_sel12", 12);
        do_reset();
        checks++;
        if (cfg_err !== 1'b0) begin $display("FAIL under_clear: got %b expected 0", cfg_err); fails++; end
    endtask

    task automatic test_back_to_back();
        logic e;
        shift_bits(6'd3, 6);
        ccff_head = 1'b1;
        cfg_en = 1'b1;
        cfg_load = 1'b1;
        tick();
        cfg_en = 1'b0;
        cfg_load = 1'b0;
        checks++;
        if (cfg_err !== 1'b0) begin $display("FAIL simul_err: got %b expected 0", cfg_err); fails++; end
        test_route("simul_sel3", 3);
        for (int t = 0; t < 4; t++) begin
            rand_in();
            in[3] = t[0];
            exp_q.push_back(in[3]);
            #1;
            checks++;
            if (out_r === in[3] && t > 0) begin
                $display("FAIL outreg_latency: out_r=%b changed before edge", out_r);
                fails++;
            end
            tick();
            e = exp_q.pop_front();
            checks++;
            if (out_r !== e) begin $display("FAIL outreg_track: out_r=%b expected %b", out_r, e); fails++; end
        end
        do_load();
        checks++;
        if (cfg_err !== 1'b1) begin $display("FAIL simul_cnt_restart: got %b expected 1", cfg_err); fails++; end
        shift_bits(6'b000011, 2);
        in = '1;
        in[0] = 1'b0;
        cfg_en = 1'b1;
        cfg_load = 1'b1;
        prog_reset_n = 1'b0;
        tick();
        prog_reset_n = 1'b1;
        cfg_en = 1'b0;
        cfg_load = 1'b0;
        #1;
        checks++;
        if (cfg_err !== 1'b0 || ccff_tail !== 1'b0 || sel_valid !== 1'b1 || out_r !== 1'b0 || out !== 1'b0) begin
            $display("FAIL midreset_state: err=%b tail=%b valid=%b out_r=%b out=%b expected 0 0 1 0 0",
                     cfg_err, ccff_tail, sel_valid, out_r, out);
            fails++;
        end
        shift_bits(6'd0, 5);
        checks++;
        if (ccff_tail !== 1'b0) begin $display("FAIL midreset_sreg: tail=%b expected 0", ccff_tail); fails++; end
        do_load();
        checks++;
        if (cfg_err !== 1'b1) begin $display("FAIL midreset_cnt: err=%b expected 1", cfg_err); fails++; end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_out_of_range();
        test_chain();
        test_under_shift();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/mux_tree_tapbuf_cfgchain.md
# mux_tree_tapbuf_cfgchain

Parametrised routing multiplexer with tap buffer for the fabric routing blocks, which adds its own configuration storage. It selects one of `NUM_IN` inputs using a binary select code. The select code is loaded serially through a configuration flip-flop chain (`ccff_head`/`ccff_tail`) into a shift register, then committed atomically to an active select register, so the routed path never glitches during shifting. An optional output register retimes the routed signal.

## Interface
Parameters:
- `NUM_IN`, default 38: number of routable inputs, ≥2.
- `SEL_W`, derived localparam = ceil(log2(NUM_IN)): select width (6 for 38).
- `OUT_REG`, default 0: 0 = combinational output through the tap buffer; 1 = output registered on `prog_clk`.

Ports:
- `prog_clk`, input, 1: the only clock.
- `prog_reset_n`, input, 1: reset, synchronous, active-low.
- `cfg_en`, input, 1: shift enable for the configuration chain.
- `cfg_load`, input, 1: commit the shift register to the active select register.
- `ccff_head`, input, 1: serial configuration data in.
- `ccff_tail`, output, 1: serial configuration data out; feeds the next block's `ccff_head`.
- `in`, input, NUM_IN: routable inputs.
- `out`, output, 1: routed, buffered output.
- `sel_valid`, output, 1: active select < NUM_IN.
- `cfg_err`, output, 1: sticky under-shift error.

## Operation
- **Shift register `sreg[SEL_W-1:0]`.**
  - On an edge with `cfg_en`=1: `sreg <= {sreg[SEL_W-2:0], ccff_head}`.
  - The first bit shifted in becomes the MSB of the committed code (MSB-first serial order).
- **Tail.** `ccff_tail` = `sreg[SEL_W-1]`, a direct flop output.
- **Active select `sel[SEL_W-1:0]`.**
  - On an edge with `cfg_load`=1: `sel <= sreg` (the value before any shift on that same edge).
  - `sel` is held otherwise.
- **Shift counter `cnt`.**
  - Increments on each `cfg_en` edge and saturates at SEL_W.
  - Clears to 0 on a `cfg_load` edge. If `cfg_en` is also 1 on that edge, it clears to 1 instead.
- **Error flag.**
  - `cfg_load` with `cnt` < SEL_W sets `cfg_err`. The load is still performed.
  - `cfg_err` clears only on reset.
- **Mux function.**
  - `sel` = k with k < NUM_IN routes `in[k]`.
  - `sel` ≥ NUM_IN routes constant 1 and drives `sel_valid`=0.
- **Output path.**
  - `OUT_REG`=0: `out` = buffer(mux), combinational.
  - `OUT_REG`=1: `out` = a flop of mux, updated every edge.
- **Reset values** (edge with `prog_reset_n`=0), with reset dominating all other inputs:
  - `sreg`=0, `sel`=0, `cnt`=0.
  - `cfg_err`=0, `ccff_tail`=0.
  - Output flop = 0.
  - Consequence: after reset with `OUT_REG`=0, `out` follows `in[0]` and `sel_valid`=1.
- **No state machine beyond the counter.** Shifting and loading may interleave freely.

## Timing
- **Chain latency.** A bit presented on `ccff_head` with `cfg_en` appears on `ccff_tail` after SEL_W enabled edges. `ccff_tail` changes only on `cfg_en` edges.
- **Full configuration.** SEL_W `cfg_en` cycles, then one `cfg_load` cycle. Asserting `cfg_load` on the cycle after the last shift is the minimum.
- **Load to route.**
  - `OUT_REG`=0: `out` reflects the new `sel` in the cycle after the `cfg_load` edge (combinational from the `sel` flops).
  - `OUT_REG`=1: one further edge of latency.
- **Data path.**
  - `OUT_REG`=0: zero-cycle latency from `in` to `out`.
  - `OUT_REG`=1: one-cycle latency.
- **Glitch freedom.** `sel` never changes during shifting; `out` may change only after a `cfg_load` edge or an `in` change.
- **Simultaneous `cfg_en` and `cfg_load`.** The load captures the pre-shift `sreg`, and the shift proceeds on the same edge.
- **Reset mid-shift.** Partial `sreg` contents are discarded, `sel` returns to 0 and `cnt` to 0. The next configuration must be a full SEL_W shifts.
- **Width.** `cnt` is ceil(log2(SEL_W+1)) bits. Saturation means over-shifting (pass-through for downstream blocks) never wraps the counter.

## Test plan
- **Reset.** Hold `prog_reset_n`=0 for 2 edges with random `in`, `cfg_en`=1, `cfg_load`=1. Release. Required: `ccff_tail`=0, `cfg_err`=0, `sel_valid`=1, `out`==`in[0]` (NUM_IN=38, OUT_REG=0).
- **Full load.** NUM_IN=38. Shift 1,0,0,1,0,1 (code 37), then `cfg_load`. Required: `out` tracks `in[37]` through 4 toggles; `cfg_err`=0; `out` is unchanged during the 6 shift cycles.
- **Out of range.** Load code 40 (101000). Required: `sel_valid`=0 and `out`=1 for any `in`. Then load code 5: `sel_valid`=1 and `out`==`in[5]`.
- **Chain pass-through.** Shift 12 bits 110010_011101 continuously. Required: `ccff_tail` emits 1,1,0,0,1,0 on shift edges 6–11 (edge 1 = first shift), bit-exact; `cnt` saturates and a following `cfg_load` gives `cfg_err`=0 with `sel`=011101 (29).
- **Under-shift.** Reset, shift 3 bits, then `cfg_load`. Required: `cfg_err`=1 and `sel` = `sreg` (partial). `cfg_err` stays 1 through a later full correct load, and clears only on reset.
- **Simultaneous events and OUT_REG=1.** Assert `cfg_en` and `cfg_load` on the same edge after a full load of code 3. Required: `sel`=3, not the shifted value. With OUT_REG=1, `out` follows `in[3]` one edge later. Reset asserted mid-sequence after 2 shifts returns all state to reset values on that edge.
